// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver/transmitter types and helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_NINE,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } rx_state_e;

    typedef struct packed {
        logic [1:0] char_size;
        logic       nine_en;
        logic       pmode;
        logic       stopbits;
    } rx_cfg_t;

    localparam logic PMODE_EVEN = 1'b1;
    localparam logic PMODE_ODD  = 1'b0;

    function automatic logic [3:0] data_bits(input logic [1:0] char_size);
        return 4'd5 + {2'b00, char_size};
    endfunction

    // Only the active data bits contribute; unused MSBs are masked off.
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] char_size,
                                        input logic pmode);
        logic [7:0] m;
        m = data & (8'hFF >> (2'd3 - char_size));
        return (pmode == PMODE_EVEN) ? ^m : ~^m;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: sample-tick divider; restart_i realigns the phase to an external event.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             en_i,
    input  logic             restart_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni)
            cnt_q <= '0;
        else if (!en_i || restart_i || cnt_q == '0)
            cnt_q <= div_i;
        else
            cnt_q <= cnt_q - 1'b1;
    end

    assign tick_o = en_i && !restart_i && cnt_q == '0;

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with mid-bit sampling, start validation
// and a one-entry valid/ready holding register.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic [DIV_W-1:0] baud_div_i,
    input  logic             rx_en_i,
    input  logic [1:0]       char_size_i,
    input  logic             nine_en_i,
    input  logic             pmode_i,
    input  logic             stopbits_i,
    input  logic             rxd_i,
    output logic [7:0]       rx_data_o,
    output logic             rx_nine_o,
    output logic             perr_o,
    output logic             ferr_o,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    output logic             dorerr_o,
    output logic             busy_o
);

    localparam int              SC_W    = $clog2(OVERSAMPLE);
    localparam logic [SC_W-1:0] SC_MID  = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);

    logic [1:0]      sync_q;
    logic            prev_q;
    rx_state_e       state_q;
    logic [SC_W-1:0] sc_q;
    logic [2:0]      bitcnt_q;
    logic [7:0]      shift_q;
    logic            nine_q;
    logic            perr_n_q;
    logic            ferr_n_q;
    rx_cfg_t         cfg_q;
    logic [7:0]      rx_data_q;
    logic            rx_nine_q;
    logic            perr_q;
    logic            ferr_q;
    logic            rx_valid_q;
    logic            dorerr_q;

    logic rxs;
    logic start;
    logic tick;
    logic last_data;
    logic ferr_fin;

    assign rxs       = sync_q[1];
    assign start     = rx_en_i && state_q == S_IDLE && prev_q && !rxs;
    assign last_data = bitcnt_q == 3'(data_bits(cfg_q.char_size) - 4'd1);
    assign ferr_fin  = ferr_n_q || !rxs;

    uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .en_i     (rx_en_i),
        .restart_i(start),
        .div_i    (baud_div_i),
        .tick_o   (tick)
    );

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync_q     <= 2'b11;
            prev_q     <= 1'b1;
            state_q    <= S_IDLE;
            sc_q       <= '0;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            nine_q     <= 1'b0;
            perr_n_q   <= 1'b0;
            ferr_n_q   <= 1'b0;
            cfg_q      <= '0;
            rx_data_q  <= '0;
            rx_nine_q  <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            dorerr_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], rxd_i};
            prev_q <= rxs;
            if (rx_valid_q && rx_ready_i)
                rx_valid_q <= 1'b0;
            if (!rx_en_i) begin
                state_q  <= S_IDLE;
                dorerr_q <= 1'b0;
            end else if (start) begin
                state_q  <= S_START;
                sc_q     <= '0;
                bitcnt_q <= '0;
                shift_q  <= '0;
                nine_q   <= 1'b0;
                perr_n_q <= 1'b0;
                ferr_n_q <= 1'b0;
                cfg_q    <= '{char_size_i, nine_en_i, pmode_i, stopbits_i};
            end else if (state_q == S_WAIT_IDLE) begin
                if (rxs)
                    state_q <= S_IDLE;
            end else if (tick && state_q != S_IDLE) begin
                sc_q <= (sc_q == SC_LAST) ? '0 : sc_q + 1'b1;
                if (sc_q == SC_MID) begin
                    case (state_q)
                        S_START: state_q <= rxs ? S_IDLE : S_DATA;
                        S_DATA: begin
                            shift_q[bitcnt_q] <= rxs;
                            bitcnt_q          <= last_data ? '0 : bitcnt_q + 1'b1;
                            if (last_data)
                                state_q <= cfg_q.nine_en ? S_NINE : S_PARITY;
                        end
                        S_NINE: begin
                            nine_q  <= rxs;
                            state_q <= S_PARITY;
                        end
                        S_PARITY: begin
                            perr_n_q <= rxs != parity_bit(shift_q, cfg_q.char_size, cfg_q.pmode);
                            state_q  <= S_STOP;
                        end
                        S_STOP: begin
                            ferr_n_q <= ferr_fin;
                            bitcnt_q <= 3'd1;
                            // Last stop bit: commit unless the holder is full and not draining now.
                            if (bitcnt_q[0] == cfg_q.stopbits) begin
                                if (!rx_valid_q || rx_ready_i) begin
                                    rx_data_q  <= shift_q;
                                    rx_nine_q  <= nine_q;
                                    perr_q     <= perr_n_q;
                                    ferr_q     <= ferr_fin;
                                    rx_valid_q <= 1'b1;
                                end else begin
                                    dorerr_q <= 1'b1;
                                end
                                state_q <= ferr_fin ? S_WAIT_IDLE : S_IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign rx_data_o  = rx_data_q;
    assign rx_nine_o  = rx_nine_q;
    assign perr_o     = perr_q;
    assign ferr_o     = ferr_q;
    assign rx_valid_o = rx_valid_q;
    assign dorerr_o   = dorerr_q;
    assign busy_o     = state_q != S_IDLE;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed and randomized frames against a bit-list frame model.
module tb_uart_rx_os;

    typedef struct packed {
        logic [7:0] data;
        logic       nine;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] baud_div;
    logic        rx_en;
    logic [1:0]  char_size;
    logic        nine_en;
    logic        pmode;
    logic        stopbits;
    logic        rxd;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        rx_nine;
    logic        perr;
    logic        ferr;
    logic        rx_valid;
    logic        dorerr;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_os #(.OVERSAMPLE(16), .DIV_W(16)) dut (
        .clock_i   (clk),
        .reset_ni  (rst_n),
        .baud_div_i(baud_div),
        .rx_en_i   (rx_en),
        .char_size_i(char_size),
        .nine_en_i (nine_en),
        .pmode_i   (pmode),
        .stopbits_i(stopbits),
        .rxd_i     (rxd),
        .rx_data_o (rx_data),
        .rx_nine_o (rx_nine),
        .perr_o    (perr),
        .ferr_o    (ferr),
        .rx_valid_o(rx_valid),
        .rx_ready_i(rx_ready),
        .dorerr_o  (dorerr),
        .busy_o    (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected decode from the current config: data masked to its width, flags from what was sent.
    function automatic exp_t model(input logic [7:0] d, input logic nb, input logic flip,
                                   input logic [1:0] stops);
        exp_t e;
        e.data = 8'(32'(d) % (32'd1 << (5 + char_size)));
        e.nine = nine_en & nb;
        e.perr = flip;
        e.ferr = !stops[0] || (stopbits && !stops[1]);
        return e;
    endfunction

    // Serialises one frame from the current config; samples rx_valid before and after the
    // last stop bit's middle. Leaves the last stop level on the line.
    task automatic send(input logic [7:0] d, input logic nb, input logic flip,
                        input logic [1:0] stops, output logic ve, output logic vl);
        logic q[$];
        int n, p, ones;
        n    = 5 + int'(char_size);
        p    = 16 * (int'(baud_div) + 1);
        ones = $countones(32'(d) % (32'd1 << n));
        q.push_back(1'b0);
        for (int i = 0; i < n; i++) q.push_back(d[i]);
        if (nine_en) q.push_back(nb);
        q.push_back(((ones % 2) == int'(pmode)) ^ flip);
        q.push_back(stops[0]);
        if (stopbits) q.push_back(stops[1]);
        ve = 1'bx;
        vl = 1'bx;
        for (int k = 0; k < q.size(); k++) begin
            rxd = q[k];
            for (int j = 0; j < p; j++) begin
                if (k == q.size() - 1 && j == 1 + p / 2) ve = rx_valid;
                if (k == q.size() - 1 && j == 4 + p / 2) vl = rx_valid;
                @(negedge clk);
            end
        end
    endtask

    task automatic check_frame(input string tag, input exp_t e);
        chk({tag, "_valid"}, rx_valid, 1);
        chk({tag, "_data"}, rx_data, e.data);
        chk({tag, "_nine"}, rx_nine, e.nine);
        chk({tag, "_perr"}, perr, e.perr);
        chk({tag, "_ferr"}, ferr, e.ferr);
    endtask

    task automatic consume(input string tag);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk({tag, "_drained"}, rx_valid, 0);
    endtask

    task automatic idle_gap();
        rxd = 1'b1;
        repeat (16 * (int'(baud_div) + 1)) @(negedge clk);
    endtask

    initial begin
        logic ve, vl, nb, flip;
        logic [1:0] stops;
        logic [7:0] d;
        exp_t e;
        rst_n = 1'b0; rxd = 1'b1; rx_en = 1'b0; rx_ready = 1'b0; baud_div = '0;
        char_size = 2'd3; nine_en = 1'b0; pmode = 1'b1; stopbits = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_data", rx_data, 0);
        chk("reset_flags", {rx_nine, perr, ferr, rx_valid, dorerr, busy}, 0);
        rst_n = 1'b1; rx_en = 1'b1;
        repeat (4) @(negedge clk);

        send(8'hA5, 1'b0, 1'b0, 2'b11, ve, vl);
        chk("a5_valid_before_mid", ve, 0);
        chk("a5_valid_after_mid", vl, 1);
        idle_gap();
        check_frame("a5", model(8'hA5, 1'b0, 1'b0, 2'b11));
        consume("a5");

        char_size = 2'd0; nine_en = 1'b1;
        e = model(8'h15, 1'b1, 1'b1, 2'b11);
        send(8'h15, 1'b1, 1'b1, 2'b11, ve, vl);
        idle_gap();
        check_frame("nine", e);
        consume("nine");

        char_size = 2'd3; nine_en = 1'b0;
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        chk("glitch_busy_seen", busy, 1);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_busy_done", busy, 0);
        chk("glitch_no_frame", rx_valid, 0);

        stopbits = 1'b1;
        d = 8'($urandom);
        e = model(d, 1'b0, 1'b0, 2'b01);
        send(d, 1'b0, 1'b0, 2'b01, ve, vl);
        repeat (40) @(negedge clk);
        chk("break_wait_idle", busy, 1);
        check_frame("break", e);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        chk("break_released", busy, 0);
        consume("break");
        stopbits = 1'b0;
        idle_gap();
        send(8'h3C, 1'b0, 1'b0, 2'b11, ve, vl);
        idle_gap();
        check_frame("after_break", model(8'h3C, 1'b0, 1'b0, 2'b11));
        consume("after_break");

        send(8'h11, 1'b0, 1'b0, 2'b11, ve, vl);
        send(8'h22, 1'b0, 1'b0, 2'b11, ve, vl);
        idle_gap();
        chk("ovr_data_kept", rx_data, 8'h11);
        chk("ovr_dorerr", dorerr, 1);
        chk("ovr_valid", rx_valid, 1);
        consume("ovr");
        chk("ovr_sticky", dorerr, 1);
        rx_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("ovr_cleared", dorerr, 0);
        rx_en = 1'b1;
        repeat (4) @(negedge clk);

        send(8'h5A, 1'b0, 1'b0, 2'b11, ve, vl);
        idle_gap();
        rxd = 1'b0; repeat (16) @(negedge clk);
        rxd = 1'b1; repeat (16) @(negedge clk);
        rxd = 1'b0; repeat (8) @(negedge clk);
        chk("rst_pre_busy", busy, 1);
        chk("rst_pre_valid", rx_valid, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_async_data", rx_data, 0);
        chk("rst_async_flags", {rx_nine, perr, ferr, rx_valid, dorerr, busy}, 0);
        @(negedge clk);
        rxd = 1'b1; rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send(8'h7E, 1'b0, 1'b0, 2'b11, ve, vl);
        idle_gap();
        check_frame("post_rst", model(8'h7E, 1'b0, 1'b0, 2'b11));
        consume("post_rst");

        for (int i = 0; i < 24; i++) begin
            baud_div  = 16'($urandom_range(0, 2));
            char_size = 2'($urandom_range(0, 3));
            nine_en   = 1'($urandom_range(0, 1));
            pmode     = 1'($urandom_range(0, 1));
            stopbits  = 1'($urandom_range(0, 1));
            d         = 8'($urandom);
            nb        = 1'($urandom_range(0, 1));
            flip      = ($urandom_range(0, 3) == 0);
            stops     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            e = model(d, nb, flip, stops);
            send(d, nb, flip, stops, ve, vl);
            idle_gap();
            check_frame($sformatf("rnd%0d", i), e);
            consume($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
